// File: rtl/uart_tx.sv
// uart_tx: turns a byte plus a one-cycle strobe into a serial frame, LSB first, 8N1 by default.
// Define UART_TX_PARITY_EN to compile in the PARITY state and send an 8E1 frame.
module uart_tx #(
    parameter int CLK_DIV = 104
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_data_fresh,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx
);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_e;
`endif

    localparam logic [15:0] BAUD_LAST = 16'(CLK_DIV - 1);

    state_e      state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
    logic        bit_end;
`ifdef UART_TX_PARITY_EN
    logic        parity_q, parity_d;
`endif

    // Handshake: tx_data is taken on any cycle where tx_data_fresh and tx_ready are both 1.
    // A strobe while tx_ready is 0 is dropped without a trace.
    assign bit_end = (baud_q == BAUD_LAST);
    assign tx      = tx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        baud_d   = '0;
        bit_d    = bit_q;
        shift_d  = shift_q;
        tx_ready = 1'b0;
        tx_done  = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        if (state_q != IDLE && !bit_end) begin
            baud_d = baud_q + 16'd1;
        end

        case (state_q)
            IDLE: begin
                tx_ready = 1'b1;
                if (tx_data_fresh) begin
                    state_d  = START;
                    shift_d  = tx_data;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^tx_data;
`endif
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    tx_ready = 1'b1;
                    tx_done  = 1'b1;
                    // Accepting here goes straight to START, so frames abut with no idle gap.
                    if (tx_data_fresh) begin
                        state_d  = START;
                        shift_d  = tx_data;
`ifdef UART_TX_PARITY_EN
                        parity_d = ^tx_data;
`endif
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // The line level is registered from the next state so tx never glitches.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = parity_d;
`endif
            default: tx_d = 1'b1;
        endcase
    end

endmodule
